// File: rtl/ac97_framer.sv
// AC'97 downstream frame scheduler: merges register commands and PCM samples into
// 256-bit output frames and streams them as {sync, data} bits. Optional: AC97_FRAMER_UNDERRUN_EN.
module ac97_framer (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        down_ready,
  output logic        down_stb,
  output logic        down_sync,
  output logic        down_data,
  input  logic        cmd_stb,
  output logic        cmd_ack,
  input  logic        cmd_read,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        pcm_stb,
  output logic        pcm_ack,
  input  logic [19:0] pcm_left,
  input  logic [19:0] pcm_right,
  output logic        frame_done,
  output logic        busy
`ifdef AC97_FRAMER_UNDERRUN_EN
  ,
  input  logic        underrun_clr,
  output logic [15:0] pcm_underrun
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_bitcnt;
  logic        r_cmd_v;
  logic        r_cmd_read;
  logic [6:0]  r_cmd_addr;
  logic [15:0] r_cmd_data;
  logic        r_pcm_v;
  logic [19:0] r_pcm_left;
  logic [19:0] r_pcm_right;
  logic        r_frame_done;

  logic        w_load;
  logic        w_frame;
  logic        w_take;
  logic        w_last;
  logic [15:0] w_tag;
  logic [19:0] w_slot1;
  logic [19:0] w_slot2;
  logic [19:0] w_slot3;
  logic [19:0] w_slot4;
  logic [95:0] w_payload;
  logic [6:0]  w_idx;

  assign w_load  = (r_state == S_LOAD);
  assign w_frame = (r_state == S_FRAME);
  assign w_take  = w_frame & down_ready;
  assign w_last  = w_take & (r_bitcnt == 8'd255);

  assign w_tag   = {1'b1, r_cmd_v, r_cmd_v & ~r_cmd_read, r_pcm_v, r_pcm_v, 11'd0};
  assign w_slot1 = r_cmd_v ? {r_cmd_read, r_cmd_addr, 12'h000} : '0;
  assign w_slot2 = (r_cmd_v & ~r_cmd_read) ? {r_cmd_data, 4'h0} : '0;
  assign w_slot3 = r_pcm_v ? r_pcm_left : '0;
  assign w_slot4 = r_pcm_v ? r_pcm_right : '0;

  // Only the first 96 bits carry content; the rest of the frame is zero fill.
  assign w_payload = {w_tag, w_slot1, w_slot2, w_slot3, w_slot4};
  assign w_idx     = 7'd95 - r_bitcnt[6:0];

  assign down_stb   = w_take;
  assign down_sync  = w_frame & (r_bitcnt < 8'd16);
  assign down_data  = w_frame & (r_bitcnt < 8'd96) & w_payload[w_idx];
  assign cmd_ack    = w_load & cmd_stb;
  assign pcm_ack    = w_load & pcm_stb;
  assign frame_done = r_frame_done;
  assign busy       = w_frame;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_bitcnt <= '0;
          r_state  <= S_FRAME;
        end
        S_FRAME: begin
          if (w_take) r_bitcnt <= r_bitcnt + 8'd1;
          if (w_last) r_state <= en ? S_LOAD : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cmd_v     <= 1'b0;
      r_cmd_read  <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_pcm_v     <= 1'b0;
      r_pcm_left  <= '0;
      r_pcm_right <= '0;
    end else if (w_load) begin
      r_cmd_v <= cmd_stb;
      if (cmd_stb) begin
        r_cmd_read <= cmd_read;
        r_cmd_addr <= cmd_addr;
        r_cmd_data <= cmd_data;
      end
      r_pcm_v <= pcm_stb;
      if (pcm_stb) begin
        r_pcm_left  <= pcm_left;
        r_pcm_right <= pcm_right;
      end
    end
  end

`ifdef AC97_FRAMER_UNDERRUN_EN
  logic [15:0] r_underrun;

  assign pcm_underrun = r_underrun;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      r_underrun <= '0;
    else if (underrun_clr)
      r_underrun <= '0;
    else if (w_load & ~pcm_stb & (r_underrun != '1))
      r_underrun <= r_underrun + 16'd1;
  end
`endif

endmodule
